// File: rtl/fpc_pkg.sv
// Forbidden-pattern-code (FPC) constants and 4b<->5b code tables, shared by encode and decode sides.
// Latency: n/a (constants and pure combinational helper functions).
// Backpressure: n/a.
package fpc_pkg;

  localparam int FPC_IN_W   = 4;
  localparam int FPC_CODE_W = 5;

  // Entry n is the codeword for nibble n. No codeword contains 010 or 101,
  // so adjacent wires never switch in opposite directions within a code.
  localparam logic [15:0][FPC_CODE_W-1:0] FPC_ENC_TBL = {
    5'b11111,  // F
    5'b11110,  // E
    5'b11001,  // D
    5'b11100,  // C
    5'b10011,  // B
    5'b11000,  // A
    5'b10001,  // 9
    5'b10000,  // 8
    5'b01111,  // 7
    5'b01110,  // 6
    5'b00111,  // 5
    5'b01100,  // 4
    5'b00011,  // 3
    5'b00110,  // 2
    5'b00001,  // 1
    5'b00000   // 0
  };

  // Encode one nibble into its codeword.
  function automatic logic [FPC_CODE_W-1:0] fpc_encode(input logic [FPC_IN_W-1:0] nib);
    return FPC_ENC_TBL[nib];
  endfunction

  // Decode one codeword back to its nibble; codes outside the table decode to 0.
  function automatic logic [FPC_IN_W-1:0] fpc_decode(input logic [FPC_CODE_W-1:0] code);
    logic [FPC_IN_W-1:0] nib;
    nib = '0;
    for (int n = 0; n < 16; n++) begin
      if (FPC_ENC_TBL[n] == code) nib = FPC_IN_W'(n);
    end
    return nib;
  endfunction

endpackage

// File: rtl/fpc_enc4.sv
// 4-bit nibble to 5-bit FPC codeword table encoder.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module fpc_enc4
  import fpc_pkg::*;
(
  input  logic [FPC_IN_W-1:0]   i_nib,
  output logic [FPC_CODE_W-1:0] o_code
);

  assign o_code = fpc_encode(i_nib);

endmodule

// File: rtl/fpc_enc_stream.sv
// Splits DATA_W-bit words into nibbles, FPC-encodes them and streams LANES codes per beat, nibble 0 first.
// Latency: word accepted at edge k gives first beat valid in cycle k+1; BEATS beats per word, zero bubbles back-to-back.
// Backpressure: out_ready low holds the current beat and stalls input; in_ready rises combinationally with out_ready on the last beat.
module fpc_enc_stream
  import fpc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [FPC_CODE_W*LANES-1:0]  out_code,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy
);

  localparam int GROUPS = DATA_W / FPC_IN_W;
  localparam int BEATS  = (LANES > 0) ? GROUPS / LANES : 1;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SR_W   = FPC_CODE_W * GROUPS;
  localparam int BEAT_W = FPC_CODE_W * LANES;

  if (LANES < 1 || DATA_W < 4 || (DATA_W % (FPC_IN_W * LANES)) != 0) begin : g_bad_cfg
    $error("fpc_enc_stream: DATA_W must be a non-zero multiple of 4*LANES");
  end

  logic [SR_W-1:0]  w_codes;
  logic [SR_W-1:0]  w_shift_nxt;
  logic             w_last;
  logic             w_accept;
  logic             w_xfer;

  logic [SR_W-1:0]  r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vld;

  // One table encoder per nibble; the whole word is encoded in parallel at accept time.
  for (genvar g = 0; g < GROUPS; g++) begin : g_enc
    fpc_enc4 u_enc4 (
      .i_nib  (in_data[FPC_IN_W*g +: FPC_IN_W]),
      .o_code (w_codes[FPC_CODE_W*g +: FPC_CODE_W])
    );
  end

  // Next beat moves into the low lanes; a single-beat word has nothing left to shift in.
  if (BEATS > 1) begin : g_shift
    assign w_shift_nxt = {{BEAT_W{1'b0}}, r_shift[SR_W-1:BEAT_W]};
  end else begin : g_noshift
    assign w_shift_nxt = '0;
  end

  assign w_last    = r_vld && (r_cnt == CNT_W'(BEATS - 1));
  assign in_ready  = !rst && (!r_vld || (out_ready && w_last));
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_vld && out_ready;

  assign out_code  = r_shift[BEAT_W-1:0];
  assign out_valid = r_vld;
  assign out_last  = w_last;
  assign busy      = r_vld;

  // Load a fresh word, advance to the next beat on transfer, or retire the word after its last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
    end else if (w_accept) begin
      r_shift <= w_codes;
      r_cnt   <= '0;
      r_vld   <= 1'b1;
    end else if (w_xfer) begin
      r_shift <= w_shift_nxt;
      if (w_last) begin
        r_cnt <= '0;
        r_vld <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
